// File: rtl/dcache_bypass_resp.sv
// Uncached data-cache bypass: one outstanding port-0 request is turned into a bus read or write.
// Define DCACHE_POSTED_WRITE_EN to complete stores early through a one-entry posted write buffer.
module dcache_bypass_resp #(
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 8,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    p0_valid,
    input  logic                    p1_valid,
    input  logic [2:0]              op,
    input  logic [TAG_WIDTH-1:0]    tag,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic [OFFSET_WIDTH-1:0] p0_offset,
    input  logic [3:0]              p0_wstrb,
    input  logic [31:0]             p0_wdata,
    input  logic [1:0]              p0_size,
    input  logic                    uncached,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [31:0]             p0_rdata,
    output logic [31:0]             p1_rdata,
    output logic                    rd_req,
    output logic [31:0]             rd_addr,
    output logic [1:0]              rd_size,
    input  logic                    rd_rdy,
    input  logic                    ret_valid,
    input  logic [31:0]             ret_data,
    output logic                    wr_req,
    output logic [31:0]             wr_addr,
    output logic [1:0]              wr_size,
    output logic [3:0]              wr_strb,
    output logic [31:0]             wr_data,
    input  logic                    wr_rdy,
    input  logic                    wr_bvalid
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } state_t;

`ifdef DCACHE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    state_t      state;
    state_t      state_next;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [1:0]  req_size;
    logic        bus_done;
    logic        wb_empty;
    logic        accept;
    logic        is_cacop;
    logic        is_store;
    logic        unused_inputs;

    assign accept   = p0_valid && addr_ok;
    assign is_cacop = op[2];
    assign is_store = !op[2] && op[0];

    assign unused_inputs = ^{p1_valid, uncached, op[1]};

    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr  <= {tag, index, p0_offset};
            req_wdata <= p0_wdata;
            req_wstrb <= p0_wstrb;
            req_size  <= p0_size;
        end
    end

    // Bus responses are registered once before the FSM reacts, so completion lands two cycles after them.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_done <= 1'b0;
            p0_rdata <= '0;
        end else begin
            bus_done <= !bus_done && ((state == RD_WAIT && ret_valid) ||
                                      (state == WR_WAIT && wr_bvalid));
            if (accept)
                p0_rdata <= '0;
            else if (state == RD_WAIT && ret_valid && !bus_done)
                p0_rdata <= ret_data;
        end
    end

`ifdef DCACHE_POSTED_WRITE_EN
    logic wb_valid;
    logic wb_issued;

    // The buffer reuses the request registers; addr_ok stays low until it drains, so they cannot change.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_issued <= 1'b0;
        end else if (accept && is_store) begin
            wb_valid  <= 1'b1;
            wb_issued <= 1'b0;
        end else if (wb_valid && !wb_issued && wr_rdy) begin
            wb_issued <= 1'b1;
        end else if (wb_issued && wr_bvalid) begin
            wb_valid  <= 1'b0;
            wb_issued <= 1'b0;
        end
    end

    assign wb_empty = !wb_valid;
    assign wr_req   = wb_valid && !wb_issued;
`else
    assign wb_empty = 1'b1;
    assign wr_req   = (state == WR_REQ);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_cacop)
                        state_next = RESP;
                    else if (is_store)
                        state_next = POSTED ? RESP : WR_REQ;
                    else
                        state_next = RD_REQ;
                end
            end
            RD_REQ:  if (rd_rdy)   state_next = RD_WAIT;
            RD_WAIT: if (bus_done) state_next = RESP;
            WR_REQ:  if (wr_rdy)   state_next = WR_WAIT;
            WR_WAIT: if (bus_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign addr_ok  = (state == IDLE) && wb_empty;
    assign data_ok  = (state == RESP);
    assign rd_req   = (state == RD_REQ);
    assign rd_addr  = req_addr;
    assign rd_size  = req_size;
    assign wr_addr  = req_addr;
    assign wr_size  = req_size;
    assign wr_strb  = req_wstrb;
    assign wr_data  = req_wdata;
    assign p1_rdata = '0;

endmodule

// File: tb/tb_dcache_bypass_resp.sv
// Self-checking bench for dcache_bypass_resp: transaction-level model checked every cycle plus directed literal checks.
// Build with DCACHE_POSTED_WRITE_EN defined to exercise the posted-write configuration.
module tb_dcache_bypass_resp;

`ifdef DCACHE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_valid = 1'b0;
    logic        p1_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [19:0] tag = '0;
    logic [7:0]  index = '0;
    logic [3:0]  p0_offset = '0;
    logic [3:0]  p0_wstrb = '0;
    logic [31:0] p0_wdata = '0;
    logic [1:0]  p0_size = '0;
    logic        uncached = 1'b0;
    logic        rd_rdy = 1'b0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_data = '0;
    logic        wr_rdy = 1'b0;
    logic        wr_bvalid = 1'b0;
    logic        addr_ok, data_ok, rd_req, wr_req;
    logic [31:0] p0_rdata, p1_rdata, rd_addr, wr_addr, wr_data;
    logic [1:0]  rd_size, wr_size;
    logic [3:0]  wr_strb;

    dcache_bypass_resp dut (
        .clk(clk), .reset(reset), .p0_valid(p0_valid), .p1_valid(p1_valid), .op(op),
        .tag(tag), .index(index), .p0_offset(p0_offset), .p0_wstrb(p0_wstrb),
        .p0_wdata(p0_wdata), .p0_size(p0_size), .uncached(uncached),
        .addr_ok(addr_ok), .data_ok(data_ok), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_strb(wr_strb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_bvalid(wr_bvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: one outstanding request, completion cycle derived from acceptance or bus response.
    bit          m_busy = 1'b0;
    bit          wb_busy = 1'b0;
    int          m_kind = 0;
    int          m_done = -1;
    bit          rd_hs = 1'b0;
    bit          wr_hs = 1'b0;
    bit          resp_seen = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_rdata = '0;
    logic [3:0]  m_strb = '0;
    logic [1:0]  m_size = '0;
    bit          e_addr_ok, e_rd, e_wr, e_dok;

    always @(negedge clk) begin
        if (reset) begin
            m_busy  = 1'b0;
            wb_busy = 1'b0;
            m_done  = -1;
        end else begin
            e_addr_ok = !m_busy && !wb_busy;
            e_rd      = m_busy && m_kind == 0 && !rd_hs;
            e_wr      = (POSTED ? wb_busy : (m_busy && m_kind == 1)) && !wr_hs;
            e_dok     = m_busy && cyc == m_done;
            checkOutput("mon_addr_ok", 32'(addr_ok), 32'(e_addr_ok));
            checkOutput("mon_rd_req", 32'(rd_req), 32'(e_rd));
            checkOutput("mon_wr_req", 32'(wr_req), 32'(e_wr));
            checkOutput("mon_data_ok", 32'(data_ok), 32'(e_dok));
            checkOutput("mon_p1_rdata", p1_rdata, 32'h0);
            if (e_rd) begin
                checkOutput("mon_rd_addr", rd_addr, m_addr);
                checkOutput("mon_rd_size", 32'(rd_size), 32'(m_size));
            end
            if (e_wr) begin
                checkOutput("mon_wr_addr", wr_addr, m_addr);
                checkOutput("mon_wr_data", wr_data, m_data);
                checkOutput("mon_wr_strb", 32'(wr_strb), 32'(m_strb));
                checkOutput("mon_wr_size", 32'(wr_size), 32'(m_size));
            end
            if (e_dok) begin
                checkOutput("mon_p0_rdata", p0_rdata, m_rdata);
                m_busy = 1'b0;
            end
            if (m_busy && m_kind == 0 && rd_hs && !resp_seen && ret_valid) begin
                resp_seen = 1'b1;
                m_done    = cyc + 2;
                m_rdata   = ret_data;
            end
            if (!POSTED && m_busy && m_kind == 1 && wr_hs && !resp_seen && wr_bvalid) begin
                resp_seen = 1'b1;
                m_done    = cyc + 2;
            end
            if (POSTED && wb_busy && wr_hs && wr_bvalid)
                wb_busy = 1'b0;
            if (e_rd && rd_rdy) rd_hs = 1'b1;
            if (e_wr && wr_rdy) wr_hs = 1'b1;
            if (p0_valid && e_addr_ok) begin
                m_busy    = 1'b1;
                m_addr    = {tag, index, p0_offset};
                m_size    = p0_size;
                m_strb    = p0_wstrb;
                m_data    = p0_wdata;
                m_rdata   = '0;
                m_done    = -1;
                rd_hs     = 1'b0;
                wr_hs     = 1'b0;
                resp_seen = 1'b0;
                if (op[2]) begin
                    m_kind = 2;
                    m_done = cyc + 1;
                end else if (op[0]) begin
                    m_kind = 1;
                    if (POSTED) begin
                        m_done  = cyc + 1;
                        wb_busy = 1'b1;
                    end
                end else begin
                    m_kind = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [1:0] sz,
                                 input logic [3:0] st, input logic [31:0] d, output int acc_cyc);
        int n = 0;
        op = o; tag = a[31:12]; index = a[11:4]; p0_offset = a[3:0];
        p0_size = sz; p0_wstrb = st; p0_wdata = d; p0_valid = 1'b1;
        while (!addr_ok && n < 40) begin
            tick();
            n++;
        end
        checkOutput("accept_timeout", 32'(addr_ok), 32'd1);
        acc_cyc = cyc;
        tick();
        p0_valid = 1'b0;
    endtask

    task automatic waitDataOk(input int max_cycles, output int dcyc);
        int n = 0;
        while (!data_ok && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput("data_ok_timeout", 32'(data_ok), 32'd1);
        dcyc = cyc;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a, d, rv, bv, acc, dok;
        repeat (3) tick();
        checkOutput("reset_addr_ok", 32'(addr_ok), 32'd1);
        checkOutput("reset_data_ok", 32'(data_ok), 32'd0);
        checkOutput("reset_rd_req", 32'(rd_req), 32'd0);
        checkOutput("reset_wr_req", 32'(wr_req), 32'd0);
        checkOutput("reset_p0_rdata", p0_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // Load with an immediately ready bus; response three cycles after acceptance.
        rd_rdy = 1'b1; p1_valid = 1'b1; uncached = 1'b1;
        applyStimulus(3'b000, 32'h1C000124, 2'd2, 4'h0, 32'h0, a);
        checkOutput("load_rd_req", 32'(rd_req), 32'd1);
        checkOutput("load_rd_addr", rd_addr, 32'h1C000124);
        tick(); tick();
        ret_data = 32'hDEADBEEF; ret_valid = 1'b1; rv = cyc;
        tick();
        ret_valid = 1'b0; ret_data = '0;
        waitDataOk(20, d);
        checkOutput("load_latency", 32'(d - rv), 32'd2);
        checkOutput("load_rdata", p0_rdata, 32'hDEADBEEF);
        tick();

        // Store with wr_rdy withheld for four cycles.
        applyStimulus(3'b001, 32'h00001008, 2'd0, 4'b0100, 32'h5A5A5A5A, a);
        checkOutput("store_early_data_ok", 32'(data_ok), 32'(POSTED));
        for (int i = 0; i < 4; i++) begin
            checkOutput("store_wr_req_hold", 32'(wr_req), 32'd1);
            checkOutput("store_wr_addr", wr_addr, 32'h00001008);
            checkOutput("store_wr_strb", 32'(wr_strb), 32'h4);
            tick();
        end
        wr_rdy = 1'b1;
        tick();
        wr_rdy = 1'b0;
        checkOutput("store_wr_req_drop", 32'(wr_req), 32'd0);
        tick();
        wr_bvalid = 1'b1; bv = cyc;
        tick();
        wr_bvalid = 1'b0;
`ifdef DCACHE_POSTED_WRITE_EN
        checkOutput("posted_buffer_drained", 32'(addr_ok), 32'd1);
`else
        waitDataOk(20, d);
        checkOutput("store_latency", 32'(d - bv), 32'd2);
        checkOutput("store_rdata", p0_rdata, 32'd0);
        tick();
`endif

        // Cache operation completes with no bus traffic.
        applyStimulus(3'b101, 32'h0000_0ABC, 2'd2, 4'h0, 32'h0, a);
        checkOutput("cacop_data_ok", 32'(data_ok), 32'd1);
        checkOutput("cacop_rdata", p0_rdata, 32'd0);
        checkOutput("cacop_rd_req", 32'(rd_req), 32'd0);
        checkOutput("cacop_wr_req", 32'(wr_req), 32'd0);
        tick();

        // Back-to-back loads with p0_valid held: one acceptance every five cycles.
        op = 3'b000; tag = 20'h00000; index = 8'h04; p0_offset = 4'h0; p0_size = 2'd2;
        ret_data = 32'h11223344; ret_valid = 1'b1; p0_valid = 1'b1;
        acc = 0; dok = 0;
        for (int k = 0; k < 15; k++) begin
            if (p0_valid && addr_ok) acc++;
            if (data_ok) dok++;
            tick();
        end
        p0_valid = 1'b0; ret_valid = 1'b0;
        checkOutput("b2b_acceptances", 32'(acc), 32'd3);
        checkOutput("b2b_completions", 32'(dok), 32'd3);

        // Reset while the read request is still pending.
        rd_rdy = 1'b0;
        applyStimulus(3'b000, 32'h20000010, 2'd1, 4'h0, 32'h0, a);
        tick();
        checkOutput("rdreq_pending", 32'(rd_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_rdreq_rd_req", 32'(rd_req), 32'd0);
        checkOutput("rst_rdreq_addr_ok", 32'(addr_ok), 32'd1);

        // Reset in RD_WAIT followed by a stale response.
        rd_rdy = 1'b1;
        applyStimulus(3'b000, 32'h20000020, 2'd2, 4'h0, 32'h0, a);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_wait_rd_req", 32'(rd_req), 32'd0);
        checkOutput("rst_wait_data_ok", 32'(data_ok), 32'd0);
        checkOutput("rst_wait_addr_ok", 32'(addr_ok), 32'd1);
        ret_data = 32'h00000BAD; ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("late_ret_no_data_ok", 32'(data_ok), 32'd0);
            tick();
        end

`ifdef DCACHE_POSTED_WRITE_EN
        // Store immediately followed by a load: the load waits for the write response.
        applyStimulus(3'b001, 32'h00002004, 2'd2, 4'hF, 32'hCAFEF00D, a);
        op = 3'b000; tag = 20'h30000; index = 8'h02; p0_offset = 4'h0; p0_size = 2'd2;
        p0_valid = 1'b1;
        tick();
        wr_rdy = 1'b1;
        tick();
        wr_rdy = 1'b0;
        checkOutput("posted_blocks_load", 32'(addr_ok), 32'd0);
        checkOutput("posted_no_rd_req", 32'(rd_req), 32'd0);
        wr_bvalid = 1'b1; bv = cyc;
        tick();
        wr_bvalid = 1'b0;
        checkOutput("posted_load_accept", 32'(addr_ok), 32'd1);
        acc = cyc;
        tick();
        p0_valid = 1'b0;
        checkOutput("posted_load_after_write", 32'(acc - bv), 32'd1);
        checkOutput("posted_load_rd_req", 32'(rd_req), 32'd1);
        checkOutput("posted_load_rd_addr", rd_addr, 32'h30000020);
        tick();
        ret_data = 32'h0F0F0F0F; ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        waitDataOk(20, d);
        checkOutput("posted_load_rdata", p0_rdata, 32'h0F0F0F0F);
        tick();
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
